mem_stage_sized: RTL and testbench

//  Parametrised MEM pipeline stage: sized (byte/half/word) loads and stores against an

---
 rtl/mem_stage_pkg.sv | 69 ++++++
 rtl/mem_wait_ram.sv | 30 +++
 rtl/mem_stage_sized.sv | 128 ++++++++++++
 tb/tb_mem_stage_sized.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the sized-access MEM stage: size codes, FSM states, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  // mem_size encodings; 2'b11 is reserved and treated as a word access
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Write-port payload for one store: byte enables plus lane-replicated data
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] dat;
  } st_lane_t;

  // Half needs an even lane, word needs lane 0; bytes are always aligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = lane[0];
      default:  is_misaligned = (lane != 2'd0);
    endcase
  endfunction

  // Move the addressed lane(s) down to bit 0 and sign/zero-extend
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      MEM_BYTE: lane_extract = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: lane_extract = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:  lane_extract = word;
    endcase
  endfunction

  // Replicate store data across the word so any enabled lane sees the right bytes
  function automatic st_lane_t store_lanes(input logic [1:0]  size,
                                           input logic [1:0]  lane,
                                           input logic [31:0] value);
    st_lane_t r;
    case (size)
      MEM_BYTE: begin
        r.be  = 4'b0001 << lane;
        r.dat = {4{value[7:0]}};
      end
      MEM_HALF: begin
        r.be  = 4'b0011 << lane;
        r.dat = {2{value[15:0]}};
      end
      default: begin
        r.be  = 4'hF;
        r.dat = value;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_ram.sv
// Single-port data RAM, 32-bit words with four byte enables, no reset of contents.
// Latency: write lands at the clock edge; read is combinational (the parent registers it).
// Backpressure: none; always accepts.
import mem_stage_pkg::*;

module mem_wait_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  // Byte-masked synchronous write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_sized.sv
// MEM pipeline stage: sized loads/stores into an internal byte-enable RAM with wait states.
// Latency: stall for WAIT_CYCLES+1 cycles, load data valid in the following (DONE) cycle.
// Backpressure: mem_stall freezes upstream; misaligned requests neither stall nor access.
import mem_stage_pkg::*;

module mem_stage_sized #(
  parameter int WORD_LEN    = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic [WORD_LEN-1:0] alu_res,
  input  logic [WORD_LEN-1:0] st_value,
  output logic [WORD_LEN-1:0] data_mem_out,
  output logic                mem_stall,
  output logic                misaligned
);

  // Lane logic is hard-wired to four bytes and the counter is four bits wide
  if (WORD_LEN != 32 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_params
    $error("mem_stage_sized: WORD_LEN must be 32 and WAIT_CYCLES 0..15");
  end

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [WORD_LEN-1:0]   dout_q, dout_d;

  logic [WORD_LEN-1:0]   off;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane;
  logic                  req;
  logic                  req_ok;
  logic                  stall;
  logic                  access;
  logic                  ram_we;
  logic [31:0]           ram_rdata;
  st_lane_t              st_lane;

  // Address decode; the word index simply truncates so out-of-range addresses alias
  always_comb begin
    off        = alu_res - WORD_LEN'(BASE_ADDR);
    widx       = off[ADDR_WIDTH+1:2];
    lane       = off[1:0];
    req        = mem_r_en | mem_w_en;
    misaligned = req & is_misaligned(mem_size, lane);
    req_ok     = req & ~misaligned;
    st_lane    = store_lanes(mem_size, lane, st_value);
  end

  // Access sequencer: IDLE accepts, BUSY burns wait states, DONE releases the pipeline
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    stall   = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          stall = 1'b1;
          if (NO_WAIT) begin
            access  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      // Requests still visible here belong to the instruction just completed
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Store takes priority over load; a store leaves the load result untouched
    if (access && !mem_w_en) begin
      dout_d = lane_extract(ram_rdata, lane, mem_size, mem_unsigned);
    end
  end

  // A reset landing on the access edge must also cancel the pending store
  assign ram_we = access & mem_w_en & ~rst;

  // State, wait counter and registered load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  mem_wait_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (st_lane.be),
    .addr  (widx),
    .wdata (st_lane.dat),
    .rdata (ram_rdata)
  );

  assign data_mem_out = dout_q;
  assign mem_stall    = stall;

endmodule

// File: tb/tb_mem_stage_sized.sv
// Directed bench for mem_stage_sized: one instance with two wait states, one with none.
// Latency: n/a.
// Backpressure: every stall wait is bounded by a cycle budget.
module tb_mem_stage_sized;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;  // 0: drive the WAIT=2 instance, 1: the WAIT=0 instance
  logic        r_en = 1'b0, w_en = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'd1024, st = 32'd0;

  logic [31:0] dout2, dout0;
  logic        stall2, stall0, mis2, mis0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_sized #(.WORD_LEN(32), .ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut2 (
    .clk(clk), .rst(rst), .mem_r_en(r_en & ~sel), .mem_w_en(w_en & ~sel),
    .mem_size(size), .mem_unsigned(uns), .alu_res(addr), .st_value(st),
    .data_mem_out(dout2), .mem_stall(stall2), .misaligned(mis2));

  mem_stage_sized #(.WORD_LEN(32), .ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en & sel), .mem_w_en(w_en & sel),
    .mem_size(size), .mem_unsigned(uns), .alu_res(addr), .st_value(st),
    .data_mem_out(dout0), .mem_stall(stall0), .misaligned(mis0));

  wire [31:0] dout_s  = sel ? dout0  : dout2;
  wire        stall_s = sel ? stall0 : stall2;
  wire        mis_s   = sel ? mis0   : mis2;

  typedef struct {
    logic        sel;
    logic        r, w;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic r, input logic w, input logic [1:0] sz,
                              input logic u, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] e, input logic m);
    vec_t v;
    v.sel = s; v.r = r; v.w = w; v.size = sz; v.uns = u;
    v.addr = a; v.st = d; v.exp = e; v.mis = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    r_en = 1'b0; w_en = 1'b0;
  endtask

  // Apply one vector in an IDLE cycle, count stall cycles, check result in DONE
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    sel = v.sel; r_en = v.r; w_en = v.w; size = v.size; uns = v.uns;
    addr = v.addr; st = v.st;
    #1;
    chk({tag, "_misaligned"}, {31'd0, mis_s}, {31'd0, v.mis});
    if (v.mis) begin
      chk({tag, "_mis_nostall"}, {31'd0, stall_s}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_mis_nostall_next"}, {31'd0, stall_s}, 32'd0);
      chk({tag, "_mis_data"}, dout_s, v.exp);
      clear_req();
    end else begin
      n = 0;
      while (stall_s && n < 40) begin
        n++;
        @(posedge clk); #1;
      end
      chk({tag, "_stall_cycles"}, 32'(n), v.sel ? 32'd1 : 32'd3);
      chk({tag, "_data"}, dout_s, v.exp);
      clear_req();
      @(posedge clk); #1;  // DONE -> IDLE; next vector issues in this cycle
      chk({tag, "_idle_nostall"}, {31'd0, stall_s}, 32'd0);
    end
  endtask

  initial begin
    int split;
    // WAIT=2 instance, first segment
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd1024, 32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 1, 2'b00, 0, 32'd1025, 32'h00000080, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 32'd1025, 32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 32'd1025, 32'h0,        32'h00000080, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd1024, 32'h0,        32'hDEAD80EF, 0));
    tbl.push_back(mk(0, 0, 1, 2'b01, 0, 32'd1026, 32'h00001234, 32'hDEAD80EF, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'd1026, 32'h0,        32'h00001234, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'd1027, 32'h0,        32'h00001234, 1));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd1025, 32'h0,        32'h00001234, 1));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'd1026, 32'hFFFFFFFF, 32'h00001234, 1));
    tbl.push_back(mk(0, 0, 1, 2'b00, 0, 32'd1027, 32'h000000AB, 32'h00001234, 0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 32'd1027, 32'h0,        32'hFFFFFFAB, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 1, 32'd1026, 32'h0,        32'h0000AB34, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'd1026, 32'h0,        32'hFFFFAB34, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 0, 32'd1024, 32'h0,        32'hFFFF80EF, 0));
    tbl.push_back(mk(0, 1, 0, 2'b11, 0, 32'd1024, 32'h0,        32'hAB3480EF, 0));
    tbl.push_back(mk(0, 1, 1, 2'b10, 0, 32'd1032, 32'h11223344, 32'hAB3480EF, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd1032, 32'h0,        32'h11223344, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd5120, 32'h0,        32'hAB3480EF, 0));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'd1028, 32'h00000011, 32'hAB3480EF, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd1028, 32'h0,        32'h00000011, 0));
    split = tbl.size();
    // After the reset sequence: prior value survives, aliased store, WAIT=0 instance
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd1028, 32'h0,        32'h00000011, 0));
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 32'd5136, 32'hCAFEF00D, 32'h00000011, 0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 0, 32'd1040, 32'h0,        32'hCAFEF00D, 0));
    tbl.push_back(mk(1, 0, 1, 2'b10, 0, 32'd1040, 32'h0BADF00D, 32'h00000000, 0));
    tbl.push_back(mk(1, 1, 0, 2'b10, 0, 32'd1040, 32'h0,        32'h0BADF00D, 0));
    tbl.push_back(mk(1, 1, 0, 2'b00, 1, 32'd1043, 32'h0,        32'h0000000B, 0));
    tbl.push_back(mk(1, 1, 0, 2'b01, 1, 32'd1042, 32'h0,        32'h00000BAD, 0));
    tbl.push_back(mk(1, 0, 1, 2'b01, 0, 32'd1041, 32'h0000FFFF, 32'h00000BAD, 1));
    tbl.push_back(mk(1, 0, 1, 2'b00, 0, 32'd1044, 32'h0000007F, 32'h00000BAD, 0));
    tbl.push_back(mk(1, 1, 0, 2'b00, 0, 32'd1044, 32'h0,        32'h0000007F, 0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout2", dout2, 32'h0);
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_stall2", {31'd0, stall2}, 32'd0);
    chk("rst_stall0", {31'd0, stall0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < split; i++) run_vec(i, tbl[i]);

    // Reset arriving on the access edge of a store to 1028 must cancel it
    @(negedge clk);
    sel = 1'b0; w_en = 1'b1; r_en = 1'b0; size = 2'b10; uns = 1'b0;
    addr = 32'd1028; st = 32'h00000055;
    #1;
    chk("rstseq_stall_idle", {31'd0, stall2}, 32'd1);
    @(posedge clk); #1;
    chk("rstseq_stall_busy1", {31'd0, stall2}, 32'd1);
    @(posedge clk); #1;
    chk("rstseq_stall_busy0", {31'd0, stall2}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_req();
    rst = 1'b0;
    #1;
    chk("rstseq_stall_after", {31'd0, stall2}, 32'd0);
    chk("rstseq_dout_cleared", dout2, 32'h0);
    @(posedge clk); #1;
    chk("rstseq_stall_next", {31'd0, stall2}, 32'd0);

    for (int i = split; i < tbl.size(); i++) run_vec(i, tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so a wedged DUT still yields a summary
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
